mem_port_arbiter: RTL and testbench

//  Shares one fixed-latency unified memory port between the Instruction_Fetch stage (fetch port)
//  and the Memory stage (data port: ld/sd). Arbitrates, issues one access at a time, returns data

---
 rtl/mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one fixed-latency unified memory port between the instruction fetch
// stage (fetch port) and the memory stage (data port, loads and stores).
// One access is in flight at a time:
//   IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE
// The owner of the access gets a one-cycle ack pulse in RESP. The stall
// outputs hold the pipeline while a port waits for its ack.
//
// Parameters
//   ADDR_W      address width, both ports and memory
//   DATA_W      data width, data port and memory (>= 32)
//   MEM_LAT     cycles from m_valid to valid m_rdata (>= 1)
//   STARVE_MAX  consecutive data grants allowed while fetch waits
//
// Configuration macro
//   ARB_STARVE_GUARD_EN  defined: after STARVE_MAX data grants in a row with
//                        fetch waiting, fetch wins the next arbitration.
//                        undefined: strict data priority, no starve counter.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level) and address
//   if_ack/if_rdata       fetch done pulse, instruction (low 32 bits of word)
//   if_stall              if_req & ~if_ack
//   d_req/d_we/d_addr/d_wdata  data request (level), store flag, addr, data
//   d_ack/d_rdata         data done pulse, load data (stores leave it alone)
//   mem_stall             d_req & ~d_ack
//   m_valid/m_we/m_addr/m_wdata  memory issue strobe and latched request
//   m_rdata               memory read data, valid MEM_LAT cycles after m_valid
//   grant                 current owner: 00 none, 01 fetch, 10 data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_stall,
  // memory side
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  // owner indication
  output logic [1:0]        grant
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_FETCH = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  // Elaboration-time parameter sanity checks.
  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be >= 1");
  end
  if (DATA_W < 32) begin : g_bad_data_w
    $error("mem_port_arbiter: DATA_W must be >= 32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_reg,    state_next;
  logic [1:0]        grant_reg,    grant_next;
  logic              we_reg,       we_next;
  logic [ADDR_W-1:0] m_addr_reg,   m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg,  m_wdata_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0]       if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg,  d_rdata_next;

  // Arbitration decision; only acted on while in IDLE.
  logic fetch_override;
  logic pick_data;
  logic pick_fetch;

  assign pick_data  = d_req & ~fetch_override;
  assign pick_fetch = if_req & ~pick_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;

  // Fetch forces its way in once data has won STARVE_MAX times in a row
  // while fetch was waiting.
  assign fetch_override = if_req & (starve_cnt_reg == SW'(STARVE_MAX));

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (state_reg == IDLE) begin
      if (!if_req || pick_fetch) begin
        starve_cnt_next = '0;
      end else if (pick_data) begin
        starve_cnt_next = starve_cnt_reg + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  // Strict data priority: fetch never overrides a pending data request.
  assign fetch_override = 1'b0;
`endif

  // Next-state and datapath capture.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    we_next       = we_reg;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    wait_cnt_next = wait_cnt_reg;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;

    case (state_reg)
      IDLE: begin
        grant_next = GRANT_NONE;
        if (pick_data) begin
          state_next   = ISSUE;
          grant_next   = GRANT_DATA;
          we_next      = d_we;
          m_addr_next  = d_addr;
          m_wdata_next = d_wdata;
        end else if (pick_fetch) begin
          state_next  = ISSUE;
          grant_next  = GRANT_FETCH;
          we_next     = 1'b0;
          m_addr_next = if_addr;
        end
      end

      ISSUE: begin
        state_next    = WAIT;
        wait_cnt_next = CNT_W'(MEM_LAT);
      end

      WAIT: begin
        wait_cnt_next = wait_cnt_reg - CNT_W'(1);
        // The last WAIT cycle is the one in which memory presents the word.
        if (wait_cnt_reg == CNT_W'(1)) begin
          state_next = RESP;
          if (grant_reg == GRANT_FETCH) begin
            if_rdata_next = m_rdata[31:0];
          end else if (!we_reg) begin
            d_rdata_next = m_rdata;
          end
        end
      end

      RESP: begin
        state_next = IDLE;
        grant_next = GRANT_NONE;
      end

      default: begin
        state_next = IDLE;
        grant_next = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= GRANT_NONE;
      we_reg       <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      wait_cnt_reg <= '0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      we_reg       <= we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      wait_cnt_reg <= wait_cnt_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  // Outputs decode registered state only, except the stalls which must
  // react to the request level in the same cycle.
  assign m_valid   = (state_reg == ISSUE);
  assign m_we      = m_valid & we_reg;
  assign m_addr    = m_addr_reg;
  assign m_wdata   = m_wdata_reg;
  assign grant     = grant_reg;

  assign if_ack    = (state_reg == RESP) && (grant_reg == GRANT_FETCH);
  assign d_ack     = (state_reg == RESP) && (grant_reg == GRANT_DATA);
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Three instances share stimulus:
// index 0 uses MEM_LAT=2 (main checks), index 1 MEM_LAT=1, index 2 MEM_LAT=5.
// Each instance has its own latency-accurate memory model; only instance 0
// can write the shared store array.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;

  logic        if_ack_w    [3];
  logic [31:0] if_rdata_w  [3];
  logic        if_stall_w  [3];
  logic        d_ack_w     [3];
  logic [63:0] d_rdata_w   [3];
  logic        mem_stall_w [3];
  logic        m_valid_w   [3];
  logic        m_we_w      [3];
  logic [63:0] m_addr_w    [3];
  logic [63:0] m_wdata_w   [3];
  logic [63:0] m_rdata_w   [3];
  logic [1:0]  grant_w     [3];

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] INSN_WORD = 64'h0000000000730293;
  localparam logic [63:0] LOAD_WORD = 64'h1122334455667788;
  localparam logic [63:0] JUNK_WORD = 64'hBAD0BAD0BAD0BAD0;

  // Shared backing store: untouched words come from a fixed pattern.
  logic [63:0] mem_word [16];
  logic [15:0] wr_ok;

  function automatic logic [63:0] default_word(input logic [3:0] idx);
    case (idx)
      4'd2:    return INSN_WORD;
      4'd4:    return LOAD_WORD;
      default: return {16{idx}};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      wr_ok <= '0;
    end else if (m_valid_w[0] && m_we_w[0]) begin
      mem_word[m_addr_w[0][6:3]] <= m_wdata_w[0];
      wr_ok[m_addr_w[0][6:3]]    <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);

    logic [7:0]  vpipe = '0;
    logic [63:0] apipe [8];
    logic [3:0]  ridx;

    always @(posedge clk) begin
      vpipe    <= {vpipe[6:0], m_valid_w[gi]};
      apipe[0] <= m_addr_w[gi];
      for (int k = 1; k < 8; k++) apipe[k] <= apipe[k-1];
    end

    assign ridx = apipe[LAT-1][6:3];
    // Data is only meaningful exactly LAT cycles after m_valid.
    assign m_rdata_w[gi] = !vpipe[LAT-1] ? JUNK_WORD :
                           (wr_ok[ridx] ? mem_word[ridx] : default_word(ridx));

    mem_port_arbiter #(
      .ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .STARVE_MAX(4)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ack   (if_ack_w[gi]),
      .if_rdata (if_rdata_w[gi]),
      .if_stall (if_stall_w[gi]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack_w[gi]),
      .d_rdata  (d_rdata_w[gi]),
      .mem_stall(mem_stall_w[gi]),
      .m_valid  (m_valid_w[gi]),
      .m_we     (m_we_w[gi]),
      .m_addr   (m_addr_w[gi]),
      .m_wdata  (m_wdata_w[gi]),
      .m_rdata  (m_rdata_w[gi]),
      .grant    (grant_w[gi])
    );
  end

  // Reset for two edges, then leave the bench at the start of a fresh cycle
  // (cycle 0 of the next scenario) with reset low.
  task automatic do_reset();
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 64'h10;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h40;
    d_wdata = 64'hFFFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total += 6;
    if (if_ack_w[0] !== 1'b0) begin bad++; $display("FAIL reset_if_ack got=%b want=0", if_ack_w[0]); end
    if (d_ack_w[0] !== 1'b0) begin bad++; $display("FAIL reset_d_ack got=%b want=0", d_ack_w[0]); end
    if (m_valid_w[0] !== 1'b0 || m_we_w[0] !== 1'b0) begin
      bad++; $display("FAIL reset_m_valid_we got=%b%b want=00", m_valid_w[0], m_we_w[0]);
    end
    if (grant_w[0] !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant_w[0]); end
    if (m_addr_w[0] !== 64'h0 || m_wdata_w[0] !== 64'h0) begin
      bad++; $display("FAIL reset_m_addr_wdata got=%h/%h want=0/0", m_addr_w[0], m_wdata_w[0]);
    end
    if (if_rdata_w[0] !== 32'h0 || d_rdata_w[0] !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", if_rdata_w[0], d_rdata_w[0]);
    end
    $display("reset: outputs checked while reset held");
    do_reset();
  endtask

  // Scenario 1: single fetch.
  task automatic test_fetch();
    do_reset();
    if_req  = 1'b1;
    if_addr = 64'h10;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      total += 4;
      if (m_valid_w[0] !== (k == 1)) begin bad++; $display("FAIL fetch_m_valid cyc=%0d got=%b want=%b", k, m_valid_w[0], (k == 1)); end
      if (if_ack_w[0] !== (k == 4)) begin bad++; $display("FAIL fetch_if_ack cyc=%0d got=%b want=%b", k, if_ack_w[0], (k == 4)); end
      if (if_stall_w[0] !== (k <= 3)) begin bad++; $display("FAIL fetch_if_stall cyc=%0d got=%b want=%b", k, if_stall_w[0], (k <= 3)); end
      if (grant_w[0] !== ((k == 0 || k == 5) ? 2'b00 : 2'b01)) begin
        bad++; $display("FAIL fetch_grant cyc=%0d got=%b want=%b", k, grant_w[0], ((k == 0 || k == 5) ? 2'b00 : 2'b01));
      end
      if (k == 1) begin
        total += 2;
        if (m_addr_w[0] !== 64'h10) begin bad++; $display("FAIL fetch_m_addr got=%h want=10", m_addr_w[0]); end
        if (m_we_w[0] !== 1'b0) begin bad++; $display("FAIL fetch_m_we got=%b want=0", m_we_w[0]); end
      end
      if (k == 4) begin
        total++;
        if (if_rdata_w[0] !== 32'h00730293) begin bad++; $display("FAIL fetch_if_rdata got=%h want=00730293", if_rdata_w[0]); end
        $display("fetch: addr=%h ack cyc=%0d rdata=%h", if_addr, k, if_rdata_w[0]);
      end
      @(posedge clk);
      #1;
      if (k == 4) if_req = 1'b0;
    end
  endtask

  // Scenario 2: fetch and load collide, data wins.
  task automatic test_contention();
    do_reset();
    if_req  = 1'b1;
    if_addr = 64'h10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 64'h20;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      total += 5;
      if (d_ack_w[0] !== (k == 4)) begin bad++; $display("FAIL contend_d_ack cyc=%0d got=%b want=%b", k, d_ack_w[0], (k == 4)); end
      if (if_ack_w[0] !== (k == 9)) begin bad++; $display("FAIL contend_if_ack cyc=%0d got=%b want=%b", k, if_ack_w[0], (k == 9)); end
      if (m_valid_w[0] !== (k == 1 || k == 6)) begin bad++; $display("FAIL contend_m_valid cyc=%0d got=%b want=%b", k, m_valid_w[0], (k == 1 || k == 6)); end
      if (mem_stall_w[0] !== (k <= 3)) begin bad++; $display("FAIL contend_mem_stall cyc=%0d got=%b want=%b", k, mem_stall_w[0], (k <= 3)); end
      if (if_stall_w[0] !== (k <= 8)) begin bad++; $display("FAIL contend_if_stall cyc=%0d got=%b want=%b", k, if_stall_w[0], (k <= 8)); end
      if (k == 1) begin
        total++;
        if (grant_w[0] !== 2'b10 || m_addr_w[0] !== 64'h20) begin
          bad++; $display("FAIL contend_first_grant got=%b/%h want=10/20", grant_w[0], m_addr_w[0]);
        end
      end
      if (k == 6) begin
        total++;
        if (grant_w[0] !== 2'b01 || m_addr_w[0] !== 64'h10) begin
          bad++; $display("FAIL contend_second_grant got=%b/%h want=01/10", grant_w[0], m_addr_w[0]);
        end
      end
      if (k == 4) begin
        total++;
        if (d_rdata_w[0] !== LOAD_WORD) begin bad++; $display("FAIL contend_d_rdata got=%h want=%h", d_rdata_w[0], LOAD_WORD); end
        $display("load: addr=%h ack cyc=%0d rdata=%h", d_addr, k, d_rdata_w[0]);
      end
      if (k == 9) begin
        total++;
        if (if_rdata_w[0] !== 32'h00730293) begin bad++; $display("FAIL contend_if_rdata got=%h want=00730293", if_rdata_w[0]); end
        $display("fetch: addr=%h ack cyc=%0d rdata=%h", if_addr, k, if_rdata_w[0]);
      end
      @(posedge clk);
      #1;
      if (k == 4) d_req = 1'b0;
      if (k == 9) if_req = 1'b0;
    end
  endtask

  // Scenario 3: load, then back-to-back store, then load-back of the store.
  task automatic test_store();
    do_reset();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h20;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      total += 3;
      if (m_valid_w[0] !== (k == 1 || k == 6 || k == 11)) begin
        bad++; $display("FAIL store_m_valid cyc=%0d got=%b want=%b", k, m_valid_w[0], (k == 1 || k == 6 || k == 11));
      end
      if (m_we_w[0] !== (k == 6)) begin bad++; $display("FAIL store_m_we cyc=%0d got=%b want=%b", k, m_we_w[0], (k == 6)); end
      if (d_ack_w[0] !== (k == 4 || k == 9 || k == 14)) begin
        bad++; $display("FAIL store_d_ack cyc=%0d got=%b want=%b", k, d_ack_w[0], (k == 4 || k == 9 || k == 14));
      end
      if (k == 6) begin
        total++;
        if (m_wdata_w[0] !== 64'hDEADBEEF || m_addr_w[0] !== 64'h40) begin
          bad++; $display("FAIL store_m_wdata_addr got=%h/%h want=deadbeef/40", m_wdata_w[0], m_addr_w[0]);
        end
      end
      if (k == 4 || k == 9) begin
        total++;
        if (d_rdata_w[0] !== LOAD_WORD) begin bad++; $display("FAIL store_d_rdata_hold cyc=%0d got=%h want=%h", k, d_rdata_w[0], LOAD_WORD); end
        $display("%s: addr=%h ack cyc=%0d d_rdata=%h", (k == 4) ? "load" : "store", d_addr, k, d_rdata_w[0]);
      end
      if (k == 14) begin
        total++;
        if (d_rdata_w[0] !== 64'hDEADBEEF) begin bad++; $display("FAIL store_readback got=%h want=00000000deadbeef", d_rdata_w[0]); end
        $display("load: addr=%h ack cyc=%0d d_rdata=%h", d_addr, k, d_rdata_w[0]);
      end
      @(posedge clk);
      #1;
      if (k == 4) begin
        d_we    = 1'b1;
        d_addr  = 64'h40;
        d_wdata = 64'hDEADBEEF;
      end
      if (k == 9) begin
        d_we   = 1'b0;
        d_addr = 64'h40;
      end
      if (k == 14) d_req = 1'b0;
    end
  endtask

  // Scenario 4: persistent data traffic against a waiting fetch.
  task automatic test_starve();
    logic [1:0] exp_grant [5];
    logic [1:0] got_grant [5];
    int n_issue;
    int n_if_ack;
`ifdef ARB_STARVE_GUARD_EN
    exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`else
    exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
    n_issue  = 0;
    n_if_ack = 0;
    do_reset();
    if_req  = 1'b1;
    if_addr = 64'h10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 64'h20;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      if (m_valid_w[0]) begin
        if (n_issue < 5) got_grant[n_issue] = grant_w[0];
        n_issue++;
      end
      if (if_ack_w[0]) n_if_ack++;
      @(posedge clk);
      #1;
    end
    total++;
    if (n_issue != 5) begin bad++; $display("FAIL starve_issue_count got=%0d want=5", n_issue); end
    for (int i = 0; i < 5 && i < n_issue; i++) begin
      total++;
      if (got_grant[i] !== exp_grant[i]) begin bad++; $display("FAIL starve_grant idx=%0d got=%b want=%b", i, got_grant[i], exp_grant[i]); end
      $display("starve: issue %0d grant=%b", i, got_grant[i]);
    end
    total++;
`ifdef ARB_STARVE_GUARD_EN
    if (n_if_ack != 1) begin bad++; $display("FAIL starve_if_ack_count got=%0d want=1", n_if_ack); end
`else
    if (n_if_ack != 0) begin bad++; $display("FAIL starve_if_ack_count got=%0d want=0", n_if_ack); end
`endif
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  // Scenario 5: reset during WAIT aborts the fetch; held request restarts.
  task automatic test_reset_abort();
    do_reset();
    if_req  = 1'b1;
    if_addr = 64'h10;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      total += 2;
      if (if_ack_w[0] !== (k == 7)) begin bad++; $display("FAIL abort_if_ack cyc=%0d got=%b want=%b", k, if_ack_w[0], (k == 7)); end
      if (m_valid_w[0] !== (k == 1 || k == 4)) begin bad++; $display("FAIL abort_m_valid cyc=%0d got=%b want=%b", k, m_valid_w[0], (k == 1 || k == 4)); end
      if (k == 3) begin
        total++;
        if (d_ack_w[0] !== 1'b0 || m_we_w[0] !== 1'b0 || grant_w[0] !== 2'b00 ||
            m_addr_w[0] !== 64'h0 || m_wdata_w[0] !== 64'h0 || if_rdata_w[0] !== 32'h0) begin
          bad++;
          $display("FAIL abort_cleared got d_ack=%b m_we=%b grant=%b m_addr=%h m_wdata=%h if_rdata=%h want all 0",
                   d_ack_w[0], m_we_w[0], grant_w[0], m_addr_w[0], m_wdata_w[0], if_rdata_w[0]);
        end
      end
      if (k == 7) begin
        total++;
        if (if_rdata_w[0] !== 32'h00730293) begin bad++; $display("FAIL abort_if_rdata got=%h want=00730293", if_rdata_w[0]); end
        $display("fetch after abort: addr=%h ack cyc=%0d rdata=%h", if_addr, k, if_rdata_w[0]);
      end
      @(posedge clk);
      #1;
      if (k == 1) reset = 1'b1;
      if (k == 2) reset = 1'b0;
      if (k == 7) if_req = 1'b0;
    end
  endtask

  // Scenario 6: ack timing follows MEM_LAT (instances with 2, 1 and 5).
  task automatic test_latency();
    int first_ack [3];
    int want_ack  [3];
    want_ack = '{4, 3, 7};
    first_ack = '{-1, -1, -1};
    do_reset();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h20;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (d_ack_w[i] && first_ack[i] < 0) begin
          first_ack[i] = k;
          total++;
          if (d_rdata_w[i] !== LOAD_WORD) begin bad++; $display("FAIL latency_d_rdata inst=%0d got=%h want=%h", i, d_rdata_w[i], LOAD_WORD); end
        end
      end
      @(posedge clk);
      #1;
    end
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (first_ack[i] != want_ack[i]) begin bad++; $display("FAIL latency_d_ack inst=%0d got_cyc=%0d want_cyc=%0d", i, first_ack[i], want_ack[i]); end
      $display("latency: inst=%0d first d_ack cyc=%0d", i, first_ack[i]);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_starve();
    test_reset_abort();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
